// File: rtl/sr_decoder.sv
// S/R line decoder: synchronises S and R, resolves them into level Q and buffers
// each set/reset event as a recovered bit in a FIFO. Define SR_DECODER_CNT_EN for event counters.
module sr_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                       CK,
    input  logic                       RN,
    input  logic                       S,
    input  logic                       R,
    input  logic                       CLR,
    output logic                       Q,
    output logic                       DOUT,
    output logic                       VALID,
    input  logic                       READY,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL,
    output logic                       ERR,
    output logic                       OVF
`ifdef SR_DECODER_CNT_EN
    ,
    output logic [7:0]                 S_CNT,
    output logic [7:0]                 R_CNT,
    output logic [7:0]                 ILL_CNT
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    // Encoding is {rs, ss} so the next state is simply the synchronised pair.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SETH = 2'b01;
    localparam logic [1:0] ST_RSTH = 2'b10;
    localparam logic [1:0] ST_ILL  = 2'b11;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    logic [SYNC_STAGES-1:0] s_sync_q;
    logic [SYNC_STAGES-1:0] r_sync_q;
    logic                   ss;
    logic                   rs;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic                   enter_set;
    logic                   enter_rst;
    logic                   enter_ill;

    logic                   q_q;
    logic                   err_q;
    logic                   ovf_q;

    logic [DEPTH-1:0]       mem_q;
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [LW-1:0]          cnt_q;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push_req;
    logic                   pop;
    logic                   push;
    logic                   drop;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            s_sync_q <= '0;
            r_sync_q <= '0;
        end else begin
            s_sync_q[0] <= S;
            r_sync_q[0] <= R;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                s_sync_q[i] <= s_sync_q[i-1];
                r_sync_q[i] <= r_sync_q[i-1];
            end
        end
    end

    assign ss = s_sync_q[SYNC_STAGES-1];
    assign rs = r_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = {rs, ss};
        enter_set = (state_d == ST_SETH) && (state_q != ST_SETH);
        enter_rst = (state_d == ST_RSTH) && (state_q != ST_RSTH);
        enter_ill = (state_d == ST_ILL)  && (state_q != ST_ILL);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enter_set) begin
                q_q <= 1'b1;
            end else if (enter_rst) begin
                q_q <= 1'b0;
            end
        end
    end

    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == LVL_MAX);
        push_req   = enter_set || enter_rst;
        pop        = !fifo_empty && READY;
        // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (CLR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= enter_set;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + LVL_ONE;
                2'b01:   cnt_q <= cnt_q - LVL_ONE;
                default: cnt_q <= cnt_q;
            endcase
            if (enter_ill) begin
                err_q <= 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef SR_DECODER_CNT_EN
    logic [7:0] s_cnt_q;
    logic [7:0] r_cnt_q;
    logic [7:0] ill_cnt_q;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            s_cnt_q   <= '0;
            r_cnt_q   <= '0;
            ill_cnt_q <= '0;
        end else if (CLR) begin
            s_cnt_q   <= '0;
            r_cnt_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            if (enter_set && (s_cnt_q != '1)) begin
                s_cnt_q <= s_cnt_q + 8'd1;
            end
            if (enter_rst && (r_cnt_q != '1)) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
            if (enter_ill && (ill_cnt_q != '1)) begin
                ill_cnt_q <= ill_cnt_q + 8'd1;
            end
        end
    end

    assign S_CNT   = s_cnt_q;
    assign R_CNT   = r_cnt_q;
    assign ILL_CNT = ill_cnt_q;
`endif

    assign Q     = q_q;
    assign DOUT  = mem_q[rd_ptr_q];
    assign VALID = !fifo_empty;
    assign LEVEL = cnt_q;
    assign ERR   = err_q;
    assign OVF   = ovf_q;

endmodule

// File: doc/sr_decoder.md
Name: sr_decoder

Overview:
- Receive-side counterpart of the gated D-logic front end.
- Samples the S/R set/reset line pair, resolves it into a stored level Q, and records illegal S&R overlaps.
- Converts each set/reset event into a recovered data bit, buffered in a small FIFO with a valid/ready output handshake.
- Sits between the S/R pulse generator and any clocked consumer of the recovered bit stream.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on each of S and R; legal range 1..4.
- DEPTH, 4, recovered-bit FIFO depth; power of two, at least 2.

Ports:
- CK  input  1  clock, rising edge.
- RN  input  1  reset, asynchronous, active-low.
- S  input  1  set line, may be asynchronous to CK.
- R  input  1  reset line, may be asynchronous to CK.
- CLR  input  1  synchronous clear: empties the FIFO and clears ERR and OVF; Q is kept.
- Q  output  1  resolved latch level.
- DOUT  output  1  FIFO head bit.
- VALID  output  1  FIFO not empty.
- READY  input  1  consumer accepts DOUT when VALID&READY at a CK edge.
- LEVEL  output  $clog2(DEPTH+1)  FIFO occupancy.
- ERR  output  1  sticky, S and R both seen high.
- OVF  output  1  sticky, event dropped because the FIFO was full.

Behaviour:
- Clocking and reset: one clock CK; reset RN is asynchronous and active-low.
- Reset values (RN=0, no clock needed): all sync flops 0, state IDLE, Q=0, DOUT=0, VALID=0, LEVEL=0, ERR=0, OVF=0, FIFO pointers 0.
- Reset mid-operation discards FIFO contents immediately.
- Synchroniser: S and R each pass SYNC_STAGES flops, giving ss and rs. No logic acts on raw S or R.
- State machine, evaluated every CK edge from (ss, rs):
  - IDLE: (0,0).
  - SETH: (1,0).
  - RSTH: (0,1).
  - ILL: (1,1).
  - The next state is always the state encoded by the current (ss, rs).
- Actions on entering a state:
  - Entering SETH from any other state: Q<=1, push bit 1.
  - Entering RSTH from any other state: Q<=0, push bit 0.
  - Entering ILL: Q held, ERR<=1, no push.
  - IDLE: Q held, no push.
  - Remaining in the same state: no push. A held level is one event.
- Latency:
  - A clean S or R level stable before edge k updates Q, and pushes the bit, at edge k+SYNC_STAGES.
  - VALID rises at that same edge when the FIFO was empty.
- FIFO:
  - DOUT is the head entry, driven combinationally from the register array.
  - Pop on VALID&READY.
  - Push and pop in one cycle: LEVEL unchanged, order preserved. This applies even when full; the pop frees space, so no overflow.
  - Push when LEVEL==DEPTH and no pop: bit dropped, OVF<=1, FIFO unchanged.
  - READY while VALID=0: ignored.
  - Pointers wrap modulo DEPTH.
- CLR:
  - Takes priority over push and pop in the same cycle.
  - Result: LEVEL=0, VALID=0, ERR=0, OVF=0.
  - The state register and Q keep tracking ss and rs.
  - A push event coincident with CLR is lost, and OVF is not set.
- ERR and OVF stay set until CLR or RN.

Optional Feature:
- SR_DECODER_CNT_EN defined: adds outputS_CNT, R_CNT and ILL_CNT, each 8 bits.
  - They increment on entry into SETH, RSTH and ILL respectively.
  - They saturate at 255.
  - Cleared by RN and by CLR.
- SR_DECODER_CNT_EN undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEPTH=4.
- Reset: drive RN=0 mid-stream with LEVEL=3 -> Q=0, VALID=0, LEVEL=0, ERR=0, OVF=0 with no CK edge; after RN=1, outputs stay quiet while S=R=0.
- Latency and decode: S=1 for 3 cycles, idle, then R=1 for 3 cycles, with READY=0 -> Q rises 2 edges after S settles, falls 2 edges after R settles; LEVEL=2; DOUT pops 1 then 0 once READY=1.
- Held level and direct transition: S=1 held 10 cycles, then R=1 with S=0 in the same cycle -> exactly two pushes (1, 0), never repeated.
- Illegal overlap: S=1, then R=1 while S still 1, then S=0 -> ERR=1 on ILL entry, Q stays 1; entering RSTH pushes 0 and Q=0; ERR stays 1 until CLR.
- Overflow and wrap: 6 alternating events with READY=0 -> LEVEL=4, OVF=1, DOUT sequence 1,0,1,0. Then READY=1 with 4 more events arriving while draining -> no further OVF, and the bits come out in order across the pointer wrap.
- CLR coincident with push and pop, LEVEL=2 -> next cycle LEVEL=0, VALID=0, ERR=OVF=0, Q follows the event. With SR_DECODER_CNT_EN defined, the counters read 0 after CLR and saturate at 255 after 300 S events.
